apb_slave_bank: RTL and testbench
=================================

Name: apb_slave_bank

Overview:
- Parametrised APB slave endpoint behind the AHB-to-APB bridge.
- Decodes the bridge's pselx into NUM_SLV independent register banks of DEPTH words each.
- Performs the APB SETUP/ACCESS handshake with programmable wait states; returns prdata, pready and pslverr.
- Replaces the fixed, combinational read-data stub with real storage, timing and error reporting.

Parameters:
- NUM_SLV, 3, number of slave banks; width of pselx.
- ADDR_W, 32, paddr width.
- DATA_W, 32, pwdata/prdata width; must be a multiple of 8.
- DEPTH, 16, words per bank; power of two, at least 2.
- WAIT_CYC, 0, wait states inserted before pready; 0 means zero-wait.
- RESET_DATA, 32'd25, reset value of every storage word.

Ports:
- hclk, input, 1, clock.
- hreset, input, 1, asynchronous active-high reset.
- pselx, input, NUM_SLV, one-hot slave select from the bridge.
- penable, input, 1, APB ACCESS phase.
- pwrite, input, 1, 1 = write, 0 = read.
- paddr, input, ADDR_W, byte address.
- pwdata, input, DATA_W, write data.
- prdata, output, DATA_W, read data, registered.
- pready, output, 1, transfer complete, registered.
- pslverr, output, 1, transfer error, registered; valid only while pready=1.

Behaviour:
- Reset: one clock hclk; reset hreset is asynchronous, active-high. While hreset=1, all registered state is cleared immediately:
  - FSM in IDLE; pready=0, pslverr=0, prdata=0, wait counter=0.
  - Every storage word = RESET_DATA.
  - Reset mid-transfer aborts the transfer; no write commits.
- Address decode:
  - Word index = paddr[clog2(DEPTH)+1:2].
  - addr_err = paddr[1:0]!=0, or any paddr bit above clog2(DEPTH)+1 set.
  - sel_err = pselx not one-hot (two or more bits set).
  - err = addr_err | sel_err.
- FSM states: IDLE, WAIT, DONE.
  - IDLE: a SETUP (|pselx && !penable) captures addr, dir, bank and err.
    - If WAIT_CYC=0: go to DONE.
    - Else: load counter=WAIT_CYC and go to WAIT.
  - WAIT: while |pselx && penable, decrement the counter; at counter==1 go to DONE.
    - psel or penable dropping in WAIT is a protocol abort: return to IDLE, no write, pready stays 0.
  - DONE: lasts exactly one cycle.
    - pready=1 and pslverr=err.
    - prdata = mem[bank][idx] for an error-free read, else 0.
    - Outputs are loaded on the edge entering DONE.
    - At the DONE clock edge, an error-free write commits pwdata to mem[bank][idx].
    - Next state is IDLE; pready, pslverr and prdata return to 0.
- Latency:
  - WAIT_CYC=0: pready is high in the first ACCESS cycle.
  - WAIT_CYC=N: pready is high in the (N+1)th ACCESS cycle.
- Back-to-back: a new SETUP in the cycle after DONE is accepted with no idle cycle.
- Read of a word in the same transfer as its write is impossible, since transfers are serial. A read immediately after a write returns the new data.
- Errored writes never modify storage; errored reads return prdata=0.
- No SETUP seen (pselx=0): FSM stays in IDLE, outputs stay 0.

Optional Feature:
- Macro APB_SLV_PSTRB_EN.
- Defined:
  - Adds input port pstrb, width DATA_W/8.
  - On write, only byte lanes with pstrb[i]=1 are updated.
  - A read with pstrb!=0 sets pslverr=1 and returns prdata=0.
- Undefined: no pstrb port; every write updates the full word.

Decomposition:
- Package apb_slv_pkg holds:
  - the FSM state enum (IDLE/WAIT/DONE) and its width;
  - the function clog2-based IDX_W;
  - the default RESET_DATA constant.
- Sub-module apb_slv_bank, instantiated NUM_SLV times by generate:
  - one DEPTH×DATA_W storage array;
  - async-reset init, write port with byte enables, registered-address read mux.
- The top level holds the decode, error logic, FSM and output registers.

Test Plan:
- Reset then read bank0 idx0 (pselx=001, paddr=0x0, WAIT_CYC=0) -> pready high in the first ACCESS cycle, prdata=25, pslverr=0.
- Write 0xDEADBEEF to bank2 paddr=0x3C, then read it back -> prdata=0xDEADBEEF; bank0 and bank1 at 0x3C still read 25.
- WAIT_CYC=3, read -> pready low for 3 ACCESS cycles and high on the 4th; penable dropped after 2 cycles -> abort, no pready, next transfer works.
- paddr=0x41 (unaligned) and paddr=0x40 (out of range), and pselx=011 write -> pslverr=1 with pready; storage unchanged; prdata=0.
- Assert hreset mid-WAIT after a write SETUP -> outputs 0 immediately; the word keeps 25; a subsequent read returns 25.
- With APB_SLV_PSTRB_EN, write 0xAABBCCDD with pstrb=0101 over 25 -> read returns 0x00BB00DD; a read with pstrb=0001 -> pslverr=1.

Source files
------------

// File: rtl/apb_slv_pkg.sv
// apb_slave_bank shared types: FSM state, index width helper, reset data.
// Optional byte strobes are enabled by APB_SLV_PSTRB_EN.
package apb_slv_pkg;
  localparam int ST_W = 2;
  typedef enum logic [ST_W-1:0] {
    IDLE,
    WAIT,
    DONE
  } state_t;

  localparam logic [31:0] RESET_DATA_DEF = 32'd25;

  function automatic int idx_w(input int depth);
    return $clog2(depth);
  endfunction
endpackage

// File: rtl/apb_slv_bank.sv
// One DEPTH x DATA_W storage bank: async-reset init, byte-enabled
// write port and read mux addressed by the decoded word index.
module apb_slv_bank
  import apb_slv_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 16,
  parameter logic [DATA_W-1:0] RESET_DATA = DATA_W'(RESET_DATA_DEF),
  localparam int IDX_W = idx_w(DEPTH),
  localparam int NB    = DATA_W / 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_we,
  input  logic [IDX_W-1:0]  i_waddr,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic [NB-1:0]     i_wbe,
  input  logic [IDX_W-1:0]  i_raddr,
  output logic [DATA_W-1:0] o_rdata
);

  logic [DATA_W-1:0] r_mem [DEPTH];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= RESET_DATA;
      end
    end else if (i_we) begin
      for (int b = 0; b < NB; b++) begin
        if (i_wbe[b]) begin
          r_mem[i_waddr][b*8 +: 8] <= i_wdata[b*8 +: 8];
        end
      end
    end
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/apb_slave_bank.sv
// APB slave endpoint: pselx decode into NUM_SLV banks, wait-state FSM,
// registered prdata/pready/pslverr. APB_SLV_PSTRB_EN adds pstrb.
module apb_slave_bank
  import apb_slv_pkg::*;
#(
  parameter int NUM_SLV  = 3,
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int DEPTH    = 16,
  parameter int WAIT_CYC = 0,
  parameter logic [DATA_W-1:0] RESET_DATA = DATA_W'(RESET_DATA_DEF)
) (
  input  logic               hclk,
  input  logic               hreset,
  input  logic [NUM_SLV-1:0] pselx,
  input  logic               penable,
  input  logic               pwrite,
  input  logic [ADDR_W-1:0]  paddr,
`ifdef APB_SLV_PSTRB_EN
  input  logic [DATA_W/8-1:0] pstrb,
`endif
  input  logic [DATA_W-1:0]  pwdata,
  output logic [DATA_W-1:0]  prdata,
  output logic               pready,
  output logic               pslverr
);

  localparam int IDX_W  = idx_w(DEPTH);
  localparam int NB     = DATA_W / 8;
  localparam int HI     = IDX_W + 2;
  localparam int BANK_W = (NUM_SLV > 1) ? $clog2(NUM_SLV) : 1;
  localparam int CNT_W  = (WAIT_CYC > 0) ? $clog2(WAIT_CYC + 1) : 1;

  state_t             r_state;
  logic [CNT_W-1:0]   r_cnt;
  logic [IDX_W-1:0]   r_idx;
  logic [BANK_W-1:0]  r_bank;
  logic               r_wr;
  logic               r_err;
  logic               r_ready;
  logic               r_slverr;
  logic [DATA_W-1:0]  r_rdata;

  logic [IDX_W-1:0]   w_idx;
  logic [ADDR_W-1:0]  w_hi;
  logic               w_addr_err;
  logic               w_sel_err;
  logic               w_strb_err;
  logic               w_err;
  logic [BANK_W-1:0]  w_bank;
  logic               w_setup;
  logic               w_access;
  logic [NB-1:0]      w_wbe;
  logic [BANK_W-1:0]  w_rd_bank;
  logic [IDX_W-1:0]   w_rd_idx;
  logic               w_nerr;
  logic               w_nwr;
  logic [DATA_W-1:0]  w_rd_out;
  logic [DATA_W-1:0]  w_rdata [NUM_SLV];
  logic [NUM_SLV-1:0] w_we;

  assign w_idx      = paddr[HI-1:2];
  assign w_hi       = paddr >> HI;
  assign w_addr_err = (|paddr[1:0]) | (|w_hi);
  assign w_sel_err  = |(pselx & (pselx - NUM_SLV'(1)));

`ifdef APB_SLV_PSTRB_EN
  assign w_strb_err = !pwrite && (|pstrb);
  assign w_wbe      = pstrb;
`else
  assign w_strb_err = 1'b0;
  assign w_wbe      = '1;
`endif

  assign w_err    = w_addr_err | w_sel_err | w_strb_err;
  assign w_setup  = (|pselx) && !penable;
  assign w_access = (|pselx) && penable;

  always_comb begin
    w_bank = '0;
    for (int i = 0; i < NUM_SLV; i++) begin
      if (pselx[i]) w_bank = BANK_W'(i);
    end
  end

  // Zero-wait transfers reach DONE straight from IDLE, before capture.
  assign w_rd_bank = (r_state == IDLE) ? w_bank : r_bank;
  assign w_rd_idx  = (r_state == IDLE) ? w_idx  : r_idx;
  assign w_nerr    = (r_state == IDLE) ? w_err  : r_err;
  assign w_nwr     = (r_state == IDLE) ? pwrite : r_wr;
  assign w_rd_out  = (!w_nerr && !w_nwr) ? w_rdata[w_rd_bank] : '0;

  for (genvar g = 0; g < NUM_SLV; g++) begin : g_bank
    assign w_we[g] = (r_state == DONE) && r_wr && !r_err &&
                     (r_bank == BANK_W'(g));

    apb_slv_bank #(
      .DATA_W     (DATA_W),
      .DEPTH      (DEPTH),
      .RESET_DATA (RESET_DATA)
    ) u_bank (
      .clk     (hclk),
      .rst     (hreset),
      .i_we    (w_we[g]),
      .i_waddr (r_idx),
      .i_wdata (pwdata),
      .i_wbe   (w_wbe),
      .i_raddr (w_rd_idx),
      .o_rdata (w_rdata[g])
    );
  end

  always_ff @(posedge hclk or posedge hreset) begin
    if (hreset) begin
      r_state  <= IDLE;
      r_cnt    <= '0;
      r_idx    <= '0;
      r_bank   <= '0;
      r_wr     <= 1'b0;
      r_err    <= 1'b0;
      r_ready  <= 1'b0;
      r_slverr <= 1'b0;
      r_rdata  <= '0;
    end else begin
      r_ready  <= 1'b0;
      r_slverr <= 1'b0;
      r_rdata  <= '0;
      unique case (r_state)
        IDLE: begin
          if (w_setup) begin
            r_idx  <= w_idx;
            r_bank <= w_bank;
            r_wr   <= pwrite;
            r_err  <= w_err;
            if (WAIT_CYC == 0) begin
              r_state  <= DONE;
              r_ready  <= 1'b1;
              r_slverr <= w_nerr;
              r_rdata  <= w_rd_out;
            end else begin
              r_cnt   <= CNT_W'(WAIT_CYC);
              r_state <= WAIT;
            end
          end
        end
        WAIT: begin
          if (!w_access) begin
            r_state <= IDLE;
          end else if (r_cnt == CNT_W'(1)) begin
            r_state  <= DONE;
            r_ready  <= 1'b1;
            r_slverr <= w_nerr;
            r_rdata  <= w_rd_out;
          end else begin
            r_cnt <= r_cnt - CNT_W'(1);
          end
        end
        DONE: begin
          r_state <= IDLE;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign prdata  = r_rdata;
  assign pready  = r_ready;
  assign pslverr = r_slverr;

endmodule

// File: tb/tb_apb_slave_bank.sv
// Scoreboard bench for apb_slave_bank: zero-wait and 3-wait instances.
module tb_apb_slave_bank;

  typedef struct {
    logic [31:0] rd;
    logic        err;
    int          lat;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [2:0]  psel [2];
  logic        pen  [2];
  logic        pwr  [2];
  logic [31:0] padr [2];
  logic [31:0] pwd  [2];
  logic [3:0]  pst  [2];

  logic [31:0] prd0, prd1;
  logic        prdy0, prdy1;
  logic        perr0, perr1;

  exp_t q0[$];
  exp_t q1[$];
  int   tests = 0;
  int   fails = 0;
  int   acc0  = 0;
  int   acc1  = 0;

  always #5 clk = ~clk;

  apb_slave_bank #(.WAIT_CYC(0)) u_dut0 (
    .hclk    (clk),
    .hreset  (rst),
    .pselx   (psel[0]),
    .penable (pen[0]),
    .pwrite  (pwr[0]),
    .paddr   (padr[0]),
`ifdef APB_SLV_PSTRB_EN
    .pstrb   (pst[0]),
`endif
    .pwdata  (pwd[0]),
    .prdata  (prd0),
    .pready  (prdy0),
    .pslverr (perr0)
  );

  apb_slave_bank #(.WAIT_CYC(3)) u_dut1 (
    .hclk    (clk),
    .hreset  (rst),
    .pselx   (psel[1]),
    .penable (pen[1]),
    .pwrite  (pwr[1]),
    .paddr   (padr[1]),
`ifdef APB_SLV_PSTRB_EN
    .pstrb   (pst[1]),
`endif
    .pwdata  (pwd[1]),
    .prdata  (prd1),
    .pready  (prdy1),
    .pslverr (perr1)
  );

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h required %h", name, act, exp);
    end
  endtask

  function automatic logic rdy(input int d);
    return (d == 0) ? prdy0 : prdy1;
  endfunction

  // Monitor: count ACCESS cycles, pop and compare on every pready.
  always @(negedge clk) begin
    exp_t e;
    if (pen[0] && psel[0] != 3'b0) acc0++; else acc0 = 0;
    if (pen[1] && psel[1] != 3'b0) acc1++; else acc1 = 0;
    if (prdy0) begin
      if (q0.size() == 0) begin
        tests++; fails++;
        $display("FAIL dut0 pready: got 1 required 0 (nothing pending)");
      end else begin
        e = q0.pop_front();
        check("dut0 prdata", prd0, e.rd);
        check("dut0 pslverr", 32'(perr0), 32'(e.err));
        check("dut0 latency", 32'(acc0), 32'(e.lat));
      end
    end
    if (prdy1) begin
      if (q1.size() == 0) begin
        tests++; fails++;
        $display("FAIL dut1 pready: got 1 required 0 (nothing pending)");
      end else begin
        e = q1.pop_front();
        check("dut1 prdata", prd1, e.rd);
        check("dut1 pslverr", 32'(perr1), 32'(e.err));
        check("dut1 latency", 32'(acc1), 32'(e.lat));
      end
    end
  end

  // Called at posedge+1; leaves the bus idle at posedge+1 so a following
  // call issues its SETUP with no idle cycle in between.
  task automatic xfer(input int d, input logic [2:0] sel, input logic wr,
                      input logic [31:0] addr, input logic [31:0] wd,
                      input logic [3:0] strb, input logic [31:0] erd,
                      input logic eerr);
    exp_t e;
    int   n;
    e.rd  = erd;
    e.err = eerr;
    e.lat = (d == 0) ? 1 : 4;
    if (d == 0) q0.push_back(e); else q1.push_back(e);
    psel[d] = sel; pen[d] = 1'b0; pwr[d] = wr;
    padr[d] = addr; pwd[d] = wd; pst[d] = strb;
    @(posedge clk); #1 pen[d] = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!rdy(d) && n < 20);
    if (!rdy(d)) begin
      tests++; fails++;
      $display("FAIL dut%0d timeout: pready 0 after %0d cycles, required 1", d, n);
      if (d == 0 && q0.size() > 0) void'(q0.pop_back());
      if (d == 1 && q1.size() > 0) void'(q1.pop_back());
    end
    @(posedge clk); #1;
    psel[d] = 3'b0; pen[d] = 1'b0;
  endtask

  task automatic rd(input int d, input logic [2:0] sel,
                    input logic [31:0] addr, input logic [31:0] erd);
    xfer(d, sel, 1'b0, addr, 32'h0, 4'h0, erd, 1'b0);
  endtask

  task automatic wr(input int d, input logic [2:0] sel,
                    input logic [31:0] addr, input logic [31:0] wd);
    xfer(d, sel, 1'b1, addr, wd, 4'hF, 32'h0, 1'b0);
  endtask

  initial begin
    exp_t e;
    for (int d = 0; d < 2; d++) begin
      psel[d] = 3'b0; pen[d] = 1'b0; pwr[d] = 1'b0;
      padr[d] = 32'h0; pwd[d] = 32'h0; pst[d] = 4'h0;
    end
    repeat (2) @(negedge clk);
    check("rst dut0 pready", 32'(prdy0), 32'h0);
    check("rst dut0 pslverr", 32'(perr0), 32'h0);
    check("rst dut0 prdata", prd0, 32'h0);
    check("rst dut1 pready", 32'(prdy1), 32'h0);
    check("rst dut1 prdata", prd1, 32'h0);
    @(posedge clk); #1 rst = 1'b0;
    @(posedge clk); #1;

    // Zero-wait instance: storage, decode and error paths.
    rd(0, 3'b001, 32'h0, 32'd25);
    wr(0, 3'b100, 32'h3C, 32'hDEADBEEF);
    rd(0, 3'b100, 32'h3C, 32'hDEADBEEF);
    rd(0, 3'b001, 32'h3C, 32'd25);
    rd(0, 3'b010, 32'h3C, 32'd25);
    xfer(0, 3'b001, 1'b0, 32'h41, 32'h0, 4'h0, 32'h0, 1'b1);
    xfer(0, 3'b100, 1'b0, 32'h3D, 32'h0, 4'h0, 32'h0, 1'b1);
    xfer(0, 3'b001, 1'b1, 32'h40, 32'h11111111, 4'hF, 32'h0, 1'b1);
    xfer(0, 3'b001, 1'b1, 32'h41, 32'h33333333, 4'hF, 32'h0, 1'b1);
    xfer(0, 3'b011, 1'b1, 32'h3C, 32'h22222222, 4'hF, 32'h0, 1'b1);
    xfer(0, 3'b110, 1'b0, 32'h3C, 32'h0, 4'h0, 32'h0, 1'b1);
    rd(0, 3'b001, 32'h0, 32'd25);
    rd(0, 3'b001, 32'h3C, 32'd25);
    rd(0, 3'b010, 32'h3C, 32'd25);
    wr(0, 3'b010, 32'h8, 32'h0BADF00D);
    rd(0, 3'b010, 32'h8, 32'h0BADF00D);
    rd(0, 3'b001, 32'h8, 32'd25);

    // Three-wait instance: latency, abort.
    rd(1, 3'b001, 32'h4, 32'd25);
    wr(1, 3'b010, 32'h10, 32'hCAFEF00D);
    rd(1, 3'b010, 32'h10, 32'hCAFEF00D);
    psel[1] = 3'b001; pen[1] = 1'b0; pwr[1] = 1'b1;
    padr[1] = 32'h4; pwd[1] = 32'h00001234;
    @(posedge clk); #1 pen[1] = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1 psel[1] = 3'b0; pen[1] = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("abort no pready", 32'(prdy1), 32'h0);
    end
    @(posedge clk); #1;
    rd(1, 3'b001, 32'h4, 32'd25);
    rd(1, 3'b100, 32'h3C, 32'd25);

    // Reset while dut1 is in WAIT and dut0 is presenting a response.
    psel[1] = 3'b010; pen[1] = 1'b0; pwr[1] = 1'b1;
    padr[1] = 32'h0; pwd[1] = 32'h55555555;
    @(posedge clk); #1 pen[1] = 1'b1;
    e.rd = 32'hDEADBEEF; e.err = 1'b0; e.lat = 1;
    q0.push_back(e);
    psel[0] = 3'b100; pen[0] = 1'b0; pwr[0] = 1'b0; padr[0] = 32'h3C;
    @(posedge clk); #1 pen[0] = 1'b1;
    @(negedge clk);
    check("pre-reset dut0 pready", 32'(prdy0), 32'h1);
    #1 rst = 1'b1;
    #1;
    check("async rst dut0 pready", 32'(prdy0), 32'h0);
    check("async rst dut0 prdata", prd0, 32'h0);
    check("async rst dut1 pready", 32'(prdy1), 32'h0);
    check("async rst dut1 pslverr", 32'(perr1), 32'h0);
    for (int d = 0; d < 2; d++) begin
      psel[d] = 3'b0; pen[d] = 1'b0; pwr[d] = 1'b0;
    end
    @(posedge clk); #1 rst = 1'b0;
    @(posedge clk); #1;
    rd(1, 3'b010, 32'h0, 32'd25);
    rd(1, 3'b010, 32'h10, 32'd25);
    rd(0, 3'b100, 32'h3C, 32'd25);
    rd(0, 3'b010, 32'h8, 32'd25);

`ifdef APB_SLV_PSTRB_EN
    xfer(0, 3'b001, 1'b1, 32'h8, 32'hAABBCCDD, 4'b0101, 32'h0, 1'b0);
    rd(0, 3'b001, 32'h8, 32'h00BB00DD);
    xfer(0, 3'b001, 1'b0, 32'h8, 32'h0, 4'b0001, 32'h0, 1'b1);
    xfer(0, 3'b010, 1'b1, 32'h8, 32'h12345678, 4'b0000, 32'h0, 1'b0);
    rd(0, 3'b010, 32'h8, 32'd25);
`endif

    repeat (3) @(negedge clk);
    check("dut0 scoreboard drained", 32'(q0.size()), 32'h0);
    check("dut1 scoreboard drained", 32'(q1.size()), 32'h0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1, "watchdog expired");
  end

endmodule
